// File: rtl/mandelbrot_iter_engine.sv
// mandelbrot_iter_engine
//
// Escape-time iteration engine for a single complex point. It runs
// z <- z^2 + c in signed fixed point Q2.(WIDTH-2), one step per clock. It stops
// when the point escapes or when the per-request iteration limit is reached,
// and then reports the iteration count and an escape flag.
//
// Optional feature: define MANDELBROT_JULIA_EN to enable Julia mode. When it is
// enabled and in_julia=1 at accept, z0 = (in_cr, in_ci) and c = (julia_cr, julia_ci).
// When the macro is undefined, in_julia, julia_cr and julia_ci are ignored.
//
// Ports:
//   clk, rst_n               clock; synchronous active-low reset
//   in_valid / in_ready      point request handshake (in_ready = IDLE)
//   in_cr, in_ci             point coordinates, signed Q2.(WIDTH-2)
//   in_max_iter              iteration limit for this point (0 = no iterations)
//   in_julia, julia_cr/ci    Julia mode select and constant (optional feature)
//   out_valid / out_ready    result handshake (out_valid = DONE)
//   out_iter                 number of completed updates
//   out_escaped              1 = escaped, 0 = limit reached
//   busy                     engine is in ITER or DONE
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its payload until that edge. ready does not
// depend combinationally on valid: in_ready and out_valid come straight from the
// state register. The engine accepts no new request in the cycle in which it
// hands off a result, so in_ready rises one cycle after DONE is left.

module mandelbrot_iter_engine #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_cr,
    input  logic [WIDTH-1:0]  in_ci,
    input  logic [ITER_W-1:0] in_max_iter,
    input  logic              in_julia,
    input  logic [WIDTH-1:0]  julia_cr,
    input  logic [WIDTH-1:0]  julia_ci,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic              busy
);

    // The extended width keeps |z|^2 and the z^2 + c sums exact.
    localparam int EW = 2*WIDTH + 2;
    localparam int FB = WIDTH - 2;
    // 4.0 in the Q4.(2*WIDTH-4) product format.
    localparam logic signed [EW-1:0] ESC_LIM = EW'(1) << (2*WIDTH-2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_d;

    logic signed [WIDTH-1:0] zr, zi, cr, ci;
    logic [ITER_W-1:0]       limit, count, count_inc;

    // ------------------------------------------------------------------
    // Start values of z and c at accept
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] z0r, z0i, c0r, c0i;

`ifdef MANDELBROT_JULIA_EN
    always_comb begin
        z0r = '0;
        z0i = '0;
        c0r = in_cr;
        c0i = in_ci;
        if (in_julia) begin
            z0r = in_cr;
            z0i = in_ci;
            c0r = julia_cr;
            c0i = julia_ci;
        end
    end
`else
    assign z0r = '0;
    assign z0i = '0;
    assign c0r = in_cr;
    assign c0i = in_ci;
    // Julia inputs are intentionally left without a function in this build.
    logic unused_julia;
    assign unused_julia = ^{in_julia, julia_cr, julia_ci};
`endif

    // ------------------------------------------------------------------
    // One iteration step, evaluated from the current z
    // ------------------------------------------------------------------
    logic signed [2*WIDTH-1:0] zr_x, zi_x, m1, m2, m3;
    logic signed [EW-1:0]      m1_e, m2_e, m3_e, cr_e, ci_e;
    logic signed [EW-1:0]      sum_sq, zr_f, zi_f, zr_n, zi_n;
    logic                      size_esc, ovf, escape, last_step;

    // Sign-extend before multiplying so that each product is exact at 2*WIDTH bits.
    assign zr_x = {{WIDTH{zr[WIDTH-1]}}, zr};
    assign zi_x = {{WIDTH{zi[WIDTH-1]}}, zi};
    assign m1   = zr_x * zr_x;
    assign m2   = zi_x * zi_x;
    assign m3   = zr_x * zi_x;

    assign m1_e = {{2{m1[2*WIDTH-1]}}, m1};
    assign m2_e = {{2{m2[2*WIDTH-1]}}, m2};
    assign m3_e = {{2{m3[2*WIDTH-1]}}, m3};
    // Shift c into the product's binary-point position.
    assign cr_e = {{(EW-WIDTH){cr[WIDTH-1]}}, cr} << FB;
    assign ci_e = {{(EW-WIDTH){ci[WIDTH-1]}}, ci} << FB;

    assign sum_sq   = m1_e + m2_e;
    assign size_esc = (sum_sq > ESC_LIM);

    assign zr_f = m1_e - m2_e + cr_e;
    assign zi_f = (m3_e <<< 1) + ci_e;
    // Arithmetic shift: truncation toward minus infinity.
    assign zr_n = zr_f >>> FB;
    assign zi_n = zi_f >>> FB;

    // A value fits in WIDTH signed bits when bits [EW-1:WIDTH-1] are all equal.
    assign ovf = !((&zr_n[EW-1:WIDTH-1]) || !(|zr_n[EW-1:WIDTH-1])) ||
                 !((&zi_n[EW-1:WIDTH-1]) || !(|zi_n[EW-1:WIDTH-1]));

    assign escape    = size_esc || ovf;
    assign count_inc = count + ITER_W'(1);
    // count < limit holds in ITER, so count_inc never wraps.
    assign last_step = (count_inc == limit);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d = (in_max_iter == '0) ? DONE : ITER;
                end
            end
            ITER: begin
                if (escape || last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zr          <= '0;
            zi          <= '0;
            cr          <= '0;
            ci          <= '0;
            limit       <= '0;
            count       <= '0;
            out_iter    <= '0;
            out_escaped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        zr          <= z0r;
                        zi          <= z0i;
                        cr          <= c0r;
                        ci          <= c0i;
                        limit       <= in_max_iter;
                        count       <= '0;
                        out_iter    <= '0;
                        out_escaped <= 1'b0;
                    end
                end
                ITER: begin
                    if (escape) begin
                        // z is left as it was; the report uses the pre-step count.
                        out_iter    <= count;
                        out_escaped <= 1'b1;
                    end else begin
                        zr    <= zr_n[WIDTH-1:0];
                        zi    <= zi_n[WIDTH-1:0];
                        count <= count_inc;
                        if (last_step) begin
                            out_iter    <= limit;
                            out_escaped <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Testbench for mandelbrot_iter_engine (WIDTH=8, ITER_W=8, 1.0 = 64).
// Directed cases use hand-derived expectations. Random cases use a reference
// model written in 64-bit integer arithmetic.

module tb_mandelbrot_iter_engine;

    localparam int WIDTH  = 8;
    localparam int ITER_W = 8;
    localparam int FB     = WIDTH - 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_cr, in_ci;
    logic [ITER_W-1:0] in_max_iter;
    logic              in_julia;
    logic [WIDTH-1:0]  julia_cr, julia_ci;
    logic              out_valid;
    logic              out_ready;
    logic [ITER_W-1:0] out_iter;
    logic              out_escaped;
    logic              busy;

    mandelbrot_iter_engine #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cr       (in_cr),
        .in_ci       (in_ci),
        .in_max_iter (in_max_iter),
        .in_julia    (in_julia),
        .julia_cr    (julia_cr),
        .julia_ci    (julia_ci),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_iter    (out_iter),
        .out_escaped (out_escaped),
        .busy        (busy)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [ITER_W:0] exp_q[$];   // {escaped, iter}
    logic [ITER_W:0] exp_pop;
    logic            mon_seen_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sx(input logic [WIDTH-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [ITER_W:0] model(input int z0r, input int z0i,
                                              input int c_r, input int c_i,
                                              input int lim);
        longint zr, zi, nr, ni, one, lo, hi;
        zr  = z0r;
        zi  = z0i;
        one = longint'(1) << FB;
        lo  = -(longint'(1) << (WIDTH-1));
        hi  = (longint'(1) << (WIDTH-1)) - 1;
        for (int k = 0; k < lim; k++) begin
            if (zr*zr + zi*zi > 4*one*one) return {1'b1, ITER_W'(k)};
            nr = (zr*zr - zi*zi + c_r*one) >>> FB;
            ni = (2*zr*zi + c_i*one) >>> FB;
            if (nr < lo || nr > hi || ni < lo || ni > hi) return {1'b1, ITER_W'(k)};
            zr = nr;
            zi = ni;
        end
        return {1'b0, ITER_W'(lim)};
    endfunction

    // ---------------- monitor: pop and compare on each handshake ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid) mon_seen_valid = 1'b1;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 32'(1), 32'(0));
            end else begin
                exp_pop = exp_q.pop_front();
                check("out_iter", 32'(out_iter), 32'(exp_pop[ITER_W-1:0]));
                check("out_escaped", 32'(out_escaped), 32'(exp_pop[ITER_W]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [WIDTH-1:0] cr, input logic [WIDTH-1:0] ci,
                        input logic [ITER_W-1:0] lim, input logic julia,
                        input logic [ITER_W:0] exp_v);
        @(posedge clk); #1;
        in_valid    = 1'b1;
        in_cr       = cr;
        in_ci       = ci;
        in_max_iter = lim;
        in_julia    = julia;
        @(negedge clk);
        check("in_ready_at_accept", 32'(in_ready), 32'(1));
        exp_q.push_back(exp_v);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_cr       = WIDTH'($urandom);
        in_ci       = WIDTH'($urandom);
        in_max_iter = ITER_W'($urandom);
    endtask

    // Counts cycles after the accept edge until out_valid; checks in_ready low meanwhile.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check("in_ready_low_busy", 32'({in_ready, busy}), 32'(2'b01));
        end while (!out_valid && lat < 400);
        if (!out_valid) check("result_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain_random;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check(tag, 32'({in_ready, out_valid, busy}), 32'(3'b100));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int lat;
        logic [WIDTH-1:0]  rcr, rci;
        logic [ITER_W-1:0] rlim;
        logic              rj;
        logic [ITER_W:0]   rexp;

        rst_n = 1'b0; in_valid = 1'b0; in_cr = '0; in_ci = '0; in_max_iter = '0;
        in_julia = 1'b0; julia_cr = '0; julia_ci = '0; out_ready = 1'b1;
        mon_seen_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_flags", 32'({in_ready, out_valid, busy}), 32'(3'b100));
        check("rst_out_iter", 32'(out_iter), 32'(0));
        check("rst_out_escaped", 32'(out_escaped), 32'(0));

        // c=0, limit 20: never escapes
        send(8'd0, 8'd0, 8'd20, 1'b0, {1'b0, 8'd20});
        wait_result(lat);
        check("lat_c0_lim20", 32'(lat), 32'(21));
        expect_idle("idle_after_c0");

        // c=1.5+1.5i: |z1|^2 = 4.5 at count 1; hold with out_ready low
        out_ready = 1'b0;
        send(8'd96, 8'd96, 8'd50, 1'b0, {1'b1, 8'd1});
        wait_result(lat);
        check("lat_c96_96", 32'(lat), 32'(3));
        repeat (3) begin
            @(negedge clk);
            check("hold_96", 32'({out_valid, in_ready, out_escaped, out_iter}), 32'({1'b1, 1'b0, 1'b1, 8'd1}));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        expect_idle("idle_after_96");

        // c=1.75: no size escape but zr overflows at z1
        send(8'd112, 8'd0, 8'd50, 1'b0, {1'b1, 8'd1});
        wait_result(lat);
        check("lat_c112", 32'(lat), 32'(3));
        expect_idle("idle_after_112");

        // limit 0: ITER skipped, then backpressure for 5 cycles
        out_ready = 1'b0;
        send(8'd96, 8'd96, 8'd0, 1'b0, {1'b0, 8'd0});
        wait_result(lat);
        check("lat_lim0", 32'(lat), 32'(1));
        repeat (5) begin
            @(negedge clk);
            check("hold_lim0", 32'({out_valid, in_ready, out_escaped, out_iter}), 32'({1'b1, 1'b0, 1'b0, 8'd0}));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        expect_idle("idle_after_lim0");

        // Reset at count=37 of a 200-step run: request dropped
        send(8'd0, 8'd0, 8'd200, 1'b0, {1'b0, 8'd200});
        repeat (37) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_flags", 32'({in_ready, out_valid, busy}), 32'(3'b100));
        check("midrst_out_iter", 32'(out_iter), 32'(0));
        check("midrst_out_escaped", 32'(out_escaped), 32'(0));
        mon_seen_valid = 1'b0;
        repeat (220) @(posedge clk);
        @(negedge clk);
        check("no_result_after_reset", 32'(mon_seen_valid), 32'(0));

        // Fresh request after reset
        send(8'd0, 8'd0, 8'd10, 1'b0, {1'b0, 8'd10});
        wait_result(lat);
        check("lat_after_reset", 32'(lat), 32'(11));
        expect_idle("idle_after_fresh");

        // Julia select with z0/point = (96,0), julia c = 0
        julia_cr = '0; julia_ci = '0;
`ifdef MANDELBROT_JULIA_EN
        send(8'd96, 8'd0, 8'd50, 1'b1, {1'b1, 8'd0});
        wait_result(lat);
        check("lat_julia", 32'(lat), 32'(2));
`else
        send(8'd96, 8'd0, 8'd50, 1'b1, {1'b1, 8'd1});
        wait_result(lat);
        check("lat_julia_ignored", 32'(lat), 32'(3));
`endif
        expect_idle("idle_after_julia");

        // Maximum limit, never escapes
        send(8'd0, 8'd0, 8'd255, 1'b0, {1'b0, 8'd255});
        wait_result(lat);
        check("lat_lim255", 32'(lat), 32'(256));
        expect_idle("idle_after_255");

        // Limit 1 on a point that would escape later
        send(8'd96, 8'd96, 8'd1, 1'b0, {1'b0, 8'd1});
        wait_result(lat);
        check("lat_lim1", 32'(lat), 32'(2));
        expect_idle("idle_after_lim1");

        // Random points, mixed modes, random backpressure
        for (int i = 0; i < 30; i++) begin
            rcr  = WIDTH'($urandom_range(0, 255));
            rci  = WIDTH'($urandom_range(0, 255));
            rlim = ITER_W'($urandom_range(0, 40));
            rj   = 1'($urandom_range(0, 1));
            julia_cr = WIDTH'($urandom_range(0, 255)) >> 1;
            julia_ci = WIDTH'($urandom_range(0, 255)) >> 1;
            rexp = model(0, 0, sx(rcr), sx(rci), int'(rlim));
`ifdef MANDELBROT_JULIA_EN
            if (rj) rexp = model(sx(rcr), sx(rci), sx(julia_cr), sx(julia_ci), int'(rlim));
`endif
            send(rcr, rci, rlim, rj, rexp);
            drain_random();
        end
        expect_idle("idle_after_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total run time
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mandelbrot_iter_engine.md
Name: mandelbrot_iter_engine

Overview:
Sequential iteration engine for one complex point. It repeats z <- z^2 + c in signed fixed point Q2.(WIDTH-2), one step per clock, until the point escapes or the programmable iteration limit is reached. It returns the iteration count and an escape flag. Both input and output use valid/ready handshakes, so the pixel scheduler can feed several engines and a colour mapper can drain them.

Parameters:
WIDTH, 8, total bits of every coordinate; format is Q2.(WIDTH-2), range [-2, 2)
ITER_W, 8, bit width of the iteration limit and of the iteration count

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
in_valid  input  1  a point request is presented
in_ready  output  1  engine can accept a request
in_cr  input  WIDTH  real part of the point, signed Q2.(WIDTH-2)
in_ci  input  WIDTH  imaginary part of the point, signed Q2.(WIDTH-2)
in_max_iter  input  ITER_W  iteration limit for this point, unsigned
in_julia  input  1  selects Julia mode for this request (optional feature)
julia_cr  input  WIDTH  Julia constant, real part (optional feature)
julia_ci  input  WIDTH  Julia constant, imaginary part (optional feature)
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_iter  output  ITER_W  number of completed updates
out_escaped  output  1  1 = escaped, 0 = limit reached
busy  output  1  engine is in state ITER or DONE

Behaviour:
- States: IDLE, ITER, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). busy = !IDLE.
- Reset (rst_n low at a rising edge, in any state, including mid-iteration):
  - state goes to IDLE.
  - z, c, count, out_iter and out_escaped clear to 0.
  - The request in flight is discarded and no result is produced.
- IDLE, when in_valid=1:
  - Latch c = (in_cr, in_ci), z = (0, 0), limit = in_max_iter, count = 0.
  - If in_max_iter == 0: go to DONE with out_iter=0, out_escaped=0. Otherwise go to ITER.
- ITER, each cycle, computed from the current z:
  - m1 = zr*zr, m2 = zi*zi, m3 = zr*zi. These are full 2*WIDTH-bit signed products in Q4.(2*WIDTH-4).
  - size = (m1 + m2) > (4 << (2*WIDTH-4)). The comparison is strict, at full precision, with no wrap.
  - zr_f = m1 - m2 + (cr << (WIDTH-2)).
  - zi_f = 2*m3 + (ci << (WIDTH-2)).
  - Both are kept at 2*WIDTH+2 bits, so no intermediate overflow is possible.
  - zr_n = zr_f >>> (WIDTH-2) and zi_n = zi_f >>> (WIDTH-2). The shift is arithmetic, which truncates toward minus infinity.
  - ovf = 1 if zr_n or zi_n lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If size or ovf: out_iter = count, out_escaped = 1, go to DONE. z is not updated.
  - Otherwise z <= (zr_n, zi_n) and count <= count+1.
    - If count+1 == limit: out_iter = limit, out_escaped = 0, go to DONE.
- DONE:
  - out_iter and out_escaped are held stable while out_valid=1 and out_ready=0.
  - When out_ready=1: go to IDLE. in_ready rises on the following cycle; there is no same-cycle re-accept.
- Latency:
  - Request accepted in cycle t. Non-escaping point: out_valid first high in cycle t+1+limit.
  - Escape detected at ITER cycle with count=k: out_valid in cycle t+2+k.
- Count never wraps, because count <= limit <= 2^ITER_W - 1.
- in_* inputs are don't-care outside IDLE. out_ready is don't-care outside DONE.

Optional Feature:
Macro MANDELBROT_JULIA_EN.
- Defined: when in_julia=1 at accept, latch z = (in_cr, in_ci) and c = (julia_cr, julia_ci). The iteration is otherwise identical. When in_julia=0, the engine runs in Mandelbrot mode.
- Not defined: in_julia, julia_cr and julia_ci are ignored (no logic attached) and the engine always runs in Mandelbrot mode.

Test Plan (WIDTH=8, ITER_W=8, so 1.0 = 64):
- c=(0,0), max_iter=20, out_ready=1 -> out_valid in cycle t+21, out_iter=20, out_escaped=0; in_ready low from t+1 until DONE is left.
- c=(96,96) (1.5+1.5i), max_iter=50 -> |z1|^2 = 4.5 > 4 detected at count=1; out_iter=1, out_escaped=1, out_valid at t+3.
- c=(112,0) (1.75), max_iter=50 -> size is 0 at z1, but zr_n overflows (4.8125); out_iter=1, out_escaped=1.
- max_iter=0, any c -> ITER is skipped; out_valid at t+1, out_iter=0, out_escaped=0. Then hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; raise out_ready -> IDLE next cycle.
- c=(0,0), max_iter=200; drive rst_n=0 at ITER count=37 -> next cycle: IDLE, in_ready=1, out_valid=0, out_iter=0, and no result is emitted. A fresh request afterwards completes normally.
- MANDELBROT_JULIA_EN defined: in_julia=1, z0=(96,0), julia c=(0,0) -> size=0 but zr_n=2.25 overflows at count=0; out_iter=0, out_escaped=1. Same stimulus without the macro -> Mandelbrot c=1.5 -> zr_n=3.75 overflows at z1; out_iter=1, out_escaped=1.
